// File: rtl/sampletest_ms_if.sv
// Job/sample channel bundle for sampletest_ms: job in (valid/ready), one subsample result out (valid/ready).
// The master modport is the job producer and sample consumer; the slave modport is the rasterizer.
interface sampletest_ms_if #(
    parameter int SIGFIG  = 24,
    parameter int AXIS    = 3,
    parameter int COLORS  = 3,
    parameter int SAMPLES = 4
);
    logic [2:0][AXIS-1:0][SIGFIG-1:0]    tri_R16S;
    logic [COLORS-1:0][SIGFIG-1:0]       color_R16U;
    logic [1:0][SIGFIG-1:0]              pixel_R16S;
    logic [SAMPLES-1:0][1:0][SIGFIG-1:0] jitter_R16S;
    logic [1:0]                          cull_mode_R16;
    logic                                in_valid_R16H;
    logic                                in_ready_R16H;
    logic [AXIS-1:0][SIGFIG-1:0]         hit_R18S;
    logic [COLORS-1:0][SIGFIG-1:0]       color_R18U;
    logic [3:0]                          samp_idx_R18U;
    logic                                hit_R18H;
    logic                                last_R18H;
    logic [15:0]                         mask_R18H;
    logic                                out_valid_R18H;
    logic                                out_ready_R18H;

    modport master (
        output tri_R16S, color_R16U, pixel_R16S, jitter_R16S, cull_mode_R16,
               in_valid_R16H, out_ready_R18H,
        input  in_ready_R16H, hit_R18S, color_R18U, samp_idx_R18U, hit_R18H,
               last_R18H, mask_R18H, out_valid_R18H
    );

    modport slave (
        input  tri_R16S, color_R16U, pixel_R16S, jitter_R16S, cull_mode_R16,
               in_valid_R16H, out_ready_R18H,
        output in_ready_R16H, hit_R18S, color_R18U, samp_idx_R18U, hit_R18H,
               last_R18H, mask_R18H, out_valid_R18H
    );
endinterface

// File: rtl/sampletest_ms.sv
// Multisample triangle coverage: tests SAMPLES jittered points of one pixel against a latched triangle.
// First sample registered the cycle after accept, then one per free slot; a stalled output holds idx and all outputs.
module sampletest_ms #(
    parameter int SIGFIG  = 24,
    parameter int RADIX   = 10,
    parameter int AXIS    = 3,
    parameter int COLORS  = 3,
    parameter int SAMPLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    sampletest_ms_if.slave bus
);
    localparam int DW = 2 * SIGFIG;

    if (SAMPLES < 1 || SAMPLES > 16 || AXIS < 3 || RADIX >= SIGFIG) begin : g_bad_param
        $error("sampletest_ms: unsupported parameter combination");
    end

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    // Only x/y of every vertex and z of vertex 0 are ever consumed.
    logic [2:0][1:0][SIGFIG-1:0]         vtx_q;
    logic [SIGFIG-1:0]                   z0_q;
    logic [COLORS-1:0][SIGFIG-1:0]       color_q;
    logic [1:0][SIGFIG-1:0]              pixel_q;
    logic [SAMPLES-1:0][1:0][SIGFIG-1:0] jitter_q;
    logic [1:0]                          cull_q;
    logic [3:0]                          idx;
    logic [15:0]                         mask_acc;

    logic [AXIS-1:0][SIGFIG-1:0]   pos_q;
    logic [COLORS-1:0][SIGFIG-1:0] color_out_q;
    logic [3:0]                    samp_idx_q;
    logic                          hit_q, last_q, out_valid_q;
    logic [15:0]                   mask_q;

    logic                          accept, slot_free, load, is_last, samp_hit;
    logic                          ccw_hit, cw_hit;
    logic [15:0]                   mask_nxt;
    logic [AXIS-1:0][SIGFIG-1:0]   pos_nxt;
    logic [1:0][SIGFIG-1:0]        jsel;
    logic [SIGFIG-1:0]             sx, sy;
    logic signed [SIGFIG-1:0]      vx [3];
    logic signed [SIGFIG-1:0]      vy [3];
    logic signed [DW-1:0]          d  [3];
    logic [2:0]                    neg, zero;

    assign accept    = (state == IDLE) && bus.in_valid_R16H;
    assign slot_free = !out_valid_q || bus.out_ready_R18H;
    assign load      = (state == RUN) && slot_free;
    assign is_last   = (idx == 4'(SAMPLES - 1));

    always_comb begin
        jsel = '0;
        for (int s = 0; s < SAMPLES; s++) begin
            if (idx == 4'(s)) jsel = jitter_q[s];
        end
        sx = pixel_q[0] + jsel[0];
        sy = pixel_q[1] + jsel[1];
        for (int i = 0; i < 3; i++) begin
            vx[i] = vtx_q[i][0] - sx;
            vy[i] = vtx_q[i][1] - sy;
        end
        // Full-precision edge functions; sign-extended before multiplying so nothing truncates.
        d[0] = DW'(vx[0]) * DW'(vy[1]) - DW'(vx[1]) * DW'(vy[0]);
        d[1] = DW'(vx[1]) * DW'(vy[2]) - DW'(vx[2]) * DW'(vy[1]);
        d[2] = DW'(vx[2]) * DW'(vy[0]) - DW'(vx[0]) * DW'(vy[2]);
        for (int e = 0; e < 3; e++) begin
            neg[e]  = d[e][DW-1];
            zero[e] = (d[e] == '0);
        end
        ccw_hit = (neg[0] || zero[0]) && neg[1] && (neg[2] || zero[2]);
        cw_hit  = !neg[0] && (!neg[1] && !zero[1]) && !neg[2];
        case (cull_q)
            2'd0:    samp_hit = ccw_hit;
            2'd1:    samp_hit = cw_hit;
            default: samp_hit = ccw_hit || cw_hit;
        endcase
        mask_nxt   = mask_acc | (16'(samp_hit) << idx);
        pos_nxt    = '0;
        pos_nxt[0] = pixel_q[0];
        pos_nxt[1] = pixel_q[1];
        pos_nxt[2] = z0_q;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid_R16H) state_nxt = RUN;
            RUN:     if (slot_free && is_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vtx_q       <= '0;
            z0_q        <= '0;
            color_q     <= '0;
            pixel_q     <= '0;
            jitter_q    <= '0;
            cull_q      <= '0;
            idx         <= '0;
            mask_acc    <= '0;
            pos_q       <= '0;
            color_out_q <= '0;
            samp_idx_q  <= '0;
            hit_q       <= 1'b0;
            last_q      <= 1'b0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    vtx_q[i][0] <= bus.tri_R16S[i][0];
                    vtx_q[i][1] <= bus.tri_R16S[i][1];
                end
                z0_q     <= bus.tri_R16S[0][2];
                color_q  <= bus.color_R16U;
                pixel_q  <= bus.pixel_R16S;
                jitter_q <= bus.jitter_R16S;
                cull_q   <= bus.cull_mode_R16;
                idx      <= '0;
                mask_acc <= '0;
            end
            // Accept never touches the output register, so a stalled last beat survives a new job.
            if (load) begin
                pos_q       <= pos_nxt;
                color_out_q <= color_q;
                samp_idx_q  <= idx;
                hit_q       <= samp_hit;
                last_q      <= is_last;
                mask_q      <= mask_nxt;
                out_valid_q <= 1'b1;
                idx         <= idx + 4'd1;
                mask_acc    <= mask_nxt;
            end else if (bus.out_ready_R18H) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready_R16H  = (state == IDLE);
    assign bus.hit_R18S       = pos_q;
    assign bus.color_R18U     = color_out_q;
    assign bus.samp_idx_R18U  = samp_idx_q;
    assign bus.hit_R18H       = hit_q;
    assign bus.last_R18H      = last_q;
    assign bus.mask_R18H      = mask_q;
    assign bus.out_valid_R18H = out_valid_q;
endmodule

// File: tb/tb_sampletest_ms.sv
// Directed bench for sampletest_ms: coverage, ties, culling, stalls, back-to-back jobs and mid-job reset.
module tb_sampletest_ms;
    localparam int SIGFIG  = 24;
    localparam int RADIX   = 10;
    localparam int AXIS    = 3;
    localparam int COLORS  = 3;
    localparam int SAMPLES = 4;
    localparam int ONE     = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    sampletest_ms_if #(.SIGFIG(SIGFIG), .AXIS(AXIS), .COLORS(COLORS), .SAMPLES(SAMPLES)) bus ();

    sampletest_ms #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .AXIS(AXIS), .COLORS(COLORS), .SAMPLES(SAMPLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
        bus.tri_R16S[0][0] = SIGFIG'(x0 * ONE);
        bus.tri_R16S[0][1] = SIGFIG'(y0 * ONE);
        bus.tri_R16S[1][0] = SIGFIG'(x1 * ONE);
        bus.tri_R16S[1][1] = SIGFIG'(y1 * ONE);
        bus.tri_R16S[2][0] = SIGFIG'(x2 * ONE);
        bus.tri_R16S[2][1] = SIGFIG'(y2 * ONE);
        for (int i = 0; i < 3; i++) bus.tri_R16S[i][2] = SIGFIG'(100 * (i + 1));
    endtask

    task automatic set_pixel(input int x, input int y);
        bus.pixel_R16S[0] = SIGFIG'(x);
        bus.pixel_R16S[1] = SIGFIG'(y);
    endtask

    task automatic set_color(input int c);
        for (int i = 0; i < COLORS; i++) bus.color_R16U[i] = SIGFIG'(c + i);
    endtask

    task automatic set_jitter_zero();
        bus.jitter_R16S = '0;
    endtask

    task automatic set_basic_job();
        set_tri(0, 0, 0, 8, 8, 0);
        set_pixel(ONE, ONE);
        bus.jitter_R16S[0][0] = SIGFIG'(0);       bus.jitter_R16S[0][1] = SIGFIG'(0);
        bus.jitter_R16S[1][0] = SIGFIG'(ONE / 2); bus.jitter_R16S[1][1] = SIGFIG'(0);
        bus.jitter_R16S[2][0] = SIGFIG'(0);       bus.jitter_R16S[2][1] = SIGFIG'(ONE / 2);
        bus.jitter_R16S[3][0] = SIGFIG'(8 * ONE); bus.jitter_R16S[3][1] = SIGFIG'(8 * ONE);
        set_color(16'h0100);
        bus.cull_mode_R16 = 2'd0;
    endtask

    // Presents the current inputs for exactly one edge; the caller has already seen in_ready high.
    task automatic accept_job();
        bus.in_valid_R16H = 1'b1;
        tick();
        bus.in_valid_R16H = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] flags;
        rst = 1'b1;
        bus.in_valid_R16H  = 1'b0;
        bus.out_ready_R18H = 1'b1;
        set_basic_job();
        tick();
        tick();
        flags = {bus.out_valid_R18H, bus.hit_R18H, bus.last_R18H, bus.samp_idx_R18U, 9'd0};
        checks++;
        if (flags !== 16'h0) $display("FAIL reset_flags: got %h expected 0000", flags);
        else passes++;
        checks++;
        if (bus.mask_R18H !== 16'h0 || bus.hit_R18S !== '0 || bus.color_R18U !== '0)
            $display("FAIL reset_data: mask=%h pos=%h color=%h expected all zero",
                     bus.mask_R18H, bus.hit_R18S, bus.color_R18U);
        else passes++;
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready_R16H !== 1'b1 || bus.out_valid_R18H !== 1'b0)
            $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0",
                     bus.in_ready_R16H, bus.out_valid_R18H);
        else passes++;
    endtask

    task automatic test_basic();
        logic [6:0]                  got, exp;
        logic [3:0]                  exp_hit;
        logic [AXIS-1:0][SIGFIG-1:0] exp_pos;
        logic [COLORS-1:0][SIGFIG-1:0] exp_col;
        exp_hit = 4'b0111;
        exp_pos = '0;
        exp_pos[0] = SIGFIG'(ONE);
        exp_pos[1] = SIGFIG'(ONE);
        exp_pos[2] = SIGFIG'(100);
        for (int i = 0; i < COLORS; i++) exp_col[i] = SIGFIG'(16'h0100 + i);
        bus.out_ready_R18H = 1'b1;
        set_basic_job();
        checks++;
        if (bus.in_ready_R16H !== 1'b1) $display("FAIL basic_ready: got %b expected 1", bus.in_ready_R16H);
        else passes++;
        accept_job();
        // Scramble every input while the job runs; results must still follow the latched job.
        set_tri(0, 0, 8, 0, 0, 8);
        set_pixel(50 * ONE, 60 * ONE);
        set_jitter_zero();
        set_color(16'h0F00);
        bus.cull_mode_R16 = 2'd1;
        for (int b = 0; b < SAMPLES; b++) begin
            tick();
            got = {bus.out_valid_R18H, bus.samp_idx_R18U, bus.hit_R18H, bus.last_R18H};
            exp = {1'b1, 4'(b), exp_hit[b], (b == SAMPLES - 1)};
            checks++;
            if (got !== exp) $display("FAIL basic_beat%0d: got %b expected %b", b, got, exp);
            else passes++;
            checks++;
            if (bus.hit_R18S !== exp_pos || bus.color_R18U !== exp_col)
                $display("FAIL basic_fields%0d: pos=%h color=%h expected %h %h",
                         b, bus.hit_R18S, bus.color_R18U, exp_pos, exp_col);
            else passes++;
            checks++;
            if (bus.in_ready_R16H !== (b == SAMPLES - 1))
                $display("FAIL basic_in_ready%0d: got %b expected %b", b, bus.in_ready_R16H, (b == SAMPLES - 1));
            else passes++;
        end
        checks++;
        if (bus.mask_R18H !== 16'h0007) $display("FAIL basic_mask: got %h expected 0007", bus.mask_R18H);
        else passes++;
        tick();
        checks++;
        if (bus.out_valid_R18H !== 1'b0) $display("FAIL basic_drain: got %b expected 0", bus.out_valid_R18H);
        else passes++;
    endtask

    task automatic test_edge_ties();
        int          px [2];
        int          py [2];
        logic        eh [2];
        logic [15:0] em [2];
        px = '{4 * ONE, 0};
        py = '{4 * ONE, 4 * ONE};
        eh = '{1'b0, 1'b1};
        em = '{16'h0000, 16'h000F};
        bus.out_ready_R18H = 1'b1;
        for (int c = 0; c < 2; c++) begin
            set_tri(0, 0, 0, 8, 8, 0);
            set_pixel(px[c], py[c]);
            set_jitter_zero();
            bus.cull_mode_R16 = 2'd0;
            accept_job();
            for (int b = 0; b < SAMPLES; b++) begin
                tick();
                checks++;
                if (bus.out_valid_R18H !== 1'b1 || bus.hit_R18H !== eh[c])
                    $display("FAIL tie%0d_hit%0d: valid=%b hit=%b expected 1/%b",
                             c, b, bus.out_valid_R18H, bus.hit_R18H, eh[c]);
                else passes++;
            end
            checks++;
            if (bus.mask_R18H !== em[c]) $display("FAIL tie%0d_mask: got %h expected %h", c, bus.mask_R18H, em[c]);
            else passes++;
            tick();
        end
    endtask

    task automatic test_culling();
        logic [3:0] exp_by_mode;
        exp_by_mode = 4'b1110;
        bus.out_ready_R18H = 1'b1;
        for (int m = 0; m < 4; m++) begin
            set_tri(0, 0, 8, 0, 0, 8);
            set_pixel(ONE, ONE);
            set_jitter_zero();
            bus.cull_mode_R16 = 2'(m);
            accept_job();
            for (int b = 0; b < SAMPLES; b++) begin
                tick();
                checks++;
                if (bus.out_valid_R18H !== 1'b1 || bus.hit_R18H !== exp_by_mode[m])
                    $display("FAIL cull_mode%0d_beat%0d: valid=%b hit=%b expected 1/%b",
                             m, b, bus.out_valid_R18H, bus.hit_R18H, exp_by_mode[m]);
                else passes++;
            end
            checks++;
            if (bus.mask_R18H !== (exp_by_mode[m] ? 16'h000F : 16'h0000))
                $display("FAIL cull_mode%0d_mask: got %h expected %h", m, bus.mask_R18H,
                         (exp_by_mode[m] ? 16'h000F : 16'h0000));
            else passes++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] got;
        bus.out_ready_R18H = 1'b1;
        set_basic_job();
        accept_job();
        tick();
        tick();
        got = {bus.out_valid_R18H, bus.samp_idx_R18U, bus.hit_R18H, bus.last_R18H};
        checks++;
        if (got !== 7'b1_0001_1_0) $display("FAIL bp_beat1: got %b expected 1000110", got);
        else passes++;
        bus.out_ready_R18H = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            got = {bus.out_valid_R18H, bus.samp_idx_R18U, bus.hit_R18H, bus.last_R18H};
            checks++;
            if (got !== 7'b1_0001_1_0 || bus.in_ready_R16H !== 1'b0)
                $display("FAIL bp_hold%0d: got %b in_ready=%b expected 1000110 in_ready=0",
                         c, got, bus.in_ready_R16H);
            else passes++;
        end
        bus.out_ready_R18H = 1'b1;
        tick();
        got = {bus.out_valid_R18H, bus.samp_idx_R18U, bus.hit_R18H, bus.last_R18H};
        checks++;
        if (got !== 7'b1_0010_1_0 || bus.in_ready_R16H !== 1'b0)
            $display("FAIL bp_beat2: got %b in_ready=%b expected 1001010 in_ready=0", got, bus.in_ready_R16H);
        else passes++;
        tick();
        got = {bus.out_valid_R18H, bus.samp_idx_R18U, bus.hit_R18H, bus.last_R18H};
        checks++;
        if (got !== 7'b1_0011_0_1 || bus.in_ready_R16H !== 1'b1 || bus.mask_R18H !== 16'h0007)
            $display("FAIL bp_beat3: got %b in_ready=%b mask=%h expected 1001101 in_ready=1 mask=0007",
                     got, bus.in_ready_R16H, bus.mask_R18H);
        else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [6:0] got, exp;
        bus.out_ready_R18H = 1'b1;
        set_basic_job();
        accept_job();
        for (int b = 0; b < SAMPLES; b++) tick();
        bus.out_ready_R18H = 1'b0;
        set_tri(0, 0, 8, 0, 0, 8);
        set_pixel(ONE, ONE);
        set_jitter_zero();
        set_color(16'h0200);
        bus.cull_mode_R16 = 2'd0;
        checks++;
        if (bus.in_ready_R16H !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", bus.in_ready_R16H);
        else passes++;
        accept_job();
        for (int c = 0; c < 2; c++) begin
            got = {bus.out_valid_R18H, bus.samp_idx_R18U, bus.hit_R18H, bus.last_R18H};
            checks++;
            if (got !== 7'b1_0011_0_1 || bus.mask_R18H !== 16'h0007 || bus.color_R18U[0] !== SIGFIG'(16'h0100))
                $display("FAIL b2b_stalled%0d: got %b mask=%h color0=%h expected 1001101 0007 000100",
                         c, got, bus.mask_R18H, bus.color_R18U[0]);
            else passes++;
            if (c == 0) tick();
        end
        bus.out_ready_R18H = 1'b1;
        for (int b = 0; b < SAMPLES; b++) begin
            tick();
            got = {bus.out_valid_R18H, bus.samp_idx_R18U, bus.hit_R18H, bus.last_R18H};
            exp = {1'b1, 4'(b), 1'b0, (b == SAMPLES - 1)};
            checks++;
            if (got !== exp || bus.color_R18U[0] !== SIGFIG'(16'h0200))
                $display("FAIL b2b_job2_beat%0d: got %b color0=%h expected %b 000200",
                         b, got, bus.color_R18U[0], exp);
            else passes++;
        end
        checks++;
        if (bus.mask_R18H !== 16'h0000) $display("FAIL b2b_job2_mask: got %h expected 0000", bus.mask_R18H);
        else passes++;
        tick();
    endtask

    task automatic test_reset_mid_job();
        bus.out_ready_R18H = 1'b1;
        set_basic_job();
        accept_job();
        tick();
        tick();
        checks++;
        if (bus.samp_idx_R18U !== 4'd1 || bus.out_valid_R18H !== 1'b1)
            $display("FAIL rstmid_beat1: idx=%0d valid=%b expected 1/1", bus.samp_idx_R18U, bus.out_valid_R18H);
        else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.out_valid_R18H !== 1'b0 || bus.in_ready_R16H !== 1'b1)
            $display("FAIL rstmid_abort: valid=%b in_ready=%b expected 0/1", bus.out_valid_R18H, bus.in_ready_R16H);
        else passes++;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (bus.out_valid_R18H !== 1'b0)
                $display("FAIL rstmid_quiet%0d: valid=%b idx=%0d expected no beat", c, bus.out_valid_R18H, bus.samp_idx_R18U);
            else passes++;
        end
    endtask

    initial begin
        bus.in_valid_R16H  = 1'b0;
        bus.out_ready_R18H = 1'b1;
        bus.cull_mode_R16  = 2'd0;
        test_reset();
        test_basic();
        test_edge_ties();
        test_culling();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
